fft4_sequencer: RTL and testbench
=================================

Name: fft4_sequencer

Overview:
- Control and buffering stage that sits directly upstream of, and feeds, the combinational radix-2 complex butterfly unit (WIDTH-bit packed operands A, B, W; results ApWB, AnWB).
- Accepts a frame of 4 complex samples over a valid/ready stream and stores them in bit-reversed order.
- Drives the external butterfly through two radix-2 stages, one butterfly per cycle, writing results back in place.
- Streams the 4 natural-order frequency bins out over a valid/ready stream.

Parameters:
- WIDTH, 32, packed complex word width. Imag in [WIDTH-1:WIDTH/2], real in [WIDTH/2-1:0]; each half is signed Q1.(WIDTH/2-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  WIDTH  input sample, packed complex
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a sample this cycle
- out_data  out  WIDTH  output bin, packed complex
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  high with bin 3 (final beat of frame)
- bf_a  out  WIDTH  butterfly operand A
- bf_b  out  WIDTH  butterfly operand B
- bf_w  out  WIDTH  butterfly twiddle W
- bf_apwb  in  WIDTH  butterfly result A+W*B
- bf_anwb  in  WIDTH  butterfly result A-W*B

Behaviour:
- Single clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge), whether idle or mid-frame:
  - state=LOAD, all counters=0; the partial frame is discarded.
  - in_ready=0 during reset, 1 from the first cycle after.
  - out_valid=0, out_last=0, out_data=0.
  - bf_a, bf_b, bf_w driven 0; buffer contents don't-care.
- State machine: LOAD -> BF -> OUT -> LOAD.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready handshake n (0..3) writes buf[rev2(n)].
  - rev2 mapping: 0->0, 1->2, 2->1, 3->3.
  - After the 4th handshake, go to BF; in_ready=0 the following cycle.
- BF:
  - 4 cycles, step counter s=0..3. Butterfly is combinational.
  - Each cycle, drive bf_a=buf[p], bf_b=buf[q], bf_w=W. At the clock edge, capture buf[p]<=bf_apwb and buf[q]<=bf_anwb.
  - Schedule:
    - s0: p=0, q=1, W0
    - s1: p=2, q=3, W0
    - s2: p=0, q=2, W0
    - s3: p=1, q=3, W1
  - Twiddles: W0 = {im 0x0000, re 0x7FFF}; W1 = -j = {im 0x8000, re 0x0000}.
  - The block does no arithmetic of its own; results are exactly what the butterfly returns.
  - Bench model of the butterfly: products summed at WIDTH bits, truncated to bits [WIDTH-2:WIDTH/2-1] (arithmetic shift by WIDTH/2-1); add/sub wrap modulo 2^(WIDTH/2); result packed {im,re}.
  - bf_* driven 0 outside BF. After s3, go to OUT.
- OUT:
  - out_data=buf[k], k=0..3, out_valid=1.
  - k advances only on out_valid&&out_ready; out_data holds stable while out_ready=0.
  - out_last=1 when k=3.
  - After the k=3 handshake: out_valid=0 next cycle, state=LOAD, in_ready=1.
- Latency: last input handshake at cycle t -> first out_valid at t+5, assuming BF starts at t+1.
- Throughput: one frame per (4 load + 4 BF + 4 out) cycles minimum. No overlap of load and output.
- in_valid outside LOAD is ignored; no sample is consumed.
- out_ready is ignored when out_valid=0.

Test Plan:
- Impulse: in_data 0x00002000,0,0,0, out_ready=1 -> four bins all 0x00002000; out_last on the 4th; first out_valid 5 cycles after the last input handshake.
- DC: four samples of 0x00001000 -> bins 0x00003FFD, 0xFFFF0001, 0x00000001, 0x00010001 (truncation error of W0=0x7FFF is bit-exact).
- Backpressure: DC frame with out_ready toggled 1,0,0,1,0,1,1 -> each bin held stable while stalled; exactly 4 handshakes in natural order; in_ready stays 0 until the final handshake.
- Reset mid-BF: assert rst_n=0 for one cycle during s2 -> next cycle out_valid=0, in_ready=1, bf_* = 0; a following impulse frame gives the correct result.
- Back-to-back: impulse frame then DC frame with in_valid held high -> second frame accepted only after the first's out_last handshake; both outputs match their values above.
- Ignored input: in_valid=1 with data 0x7FFF7FFF throughout BF/OUT -> no extra samples consumed; frame results unchanged.

Source files
------------

// File: rtl/fft4_sequencer_if.sv
// rtl/fft4_sequencer_if.sv - sample/bin streams and butterfly operand bundle for fft4_sequencer
interface fft4_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [WIDTH-1:0] bf_a;
  logic [WIDTH-1:0] bf_b;
  logic [WIDTH-1:0] bf_w;
  logic [WIDTH-1:0] bf_apwb;
  logic [WIDTH-1:0] bf_anwb;

  modport master (
    input  in_data, in_valid, out_ready, bf_apwb, bf_anwb,
    output in_ready, out_data, out_valid, out_last, bf_a, bf_b, bf_w
  );

  modport slave (
    output in_data, in_valid, out_ready, bf_apwb, bf_anwb,
    input  in_ready, out_data, out_valid, out_last, bf_a, bf_b, bf_w
  );
endinterface

// File: rtl/fft4_sequencer.sv
// rtl/fft4_sequencer.sv - 4-point FFT control: bit-reversed load, two radix-2 stages via external butterfly, natural-order output
module fft4_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  fft4_sequencer_if.master bus
);
  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] W0 = {{H{1'b0}}, 1'b0, {(H-1){1'b1}}};
  localparam logic [WIDTH-1:0] W1 = {1'b1, {(H-1){1'b0}}, {H{1'b0}}};

  typedef enum logic [1:0] {LOAD, BF, OUT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [4];

  logic [1:0]       p, q;
  logic [WIDTH-1:0] w;
  logic             in_ready, out_valid, out_last;
  logic [WIDTH-1:0] out_data, bf_a, bf_b, bf_w;

  // Butterfly schedule: stage 1 pairs (0,1),(2,3); stage 2 pairs (0,2),(1,3) with -j on the odd pair.
  always_comb begin
    p = 2'd1;
    q = 2'd3;
    w = W1;
    case (cnt_q)
      2'd0: begin p = 2'd0; q = 2'd1; w = W0; end
      2'd1: begin p = 2'd2; q = 2'd3; w = W0; end
      2'd2: begin p = 2'd0; q = 2'd2; w = W0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    bf_a      = '0;
    bf_b      = '0;
    bf_w      = '0;
    case (state_q)
      LOAD: begin
        in_ready = rst_n;
        if (bus.in_valid && in_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = BF;
        end
      end
      BF: begin
        bf_a  = mem_q[p];
        bf_b  = mem_q[q];
        bf_w  = w;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = mem_q[cnt_q];
        out_last  = (cnt_q == 2'd3);
        if (bus.out_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sample n lands at its bit-reversed slot so the output phase reads bins in natural order.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.in_valid && in_ready) begin
      mem_q[{cnt_q[0], cnt_q[1]}] <= bus.in_data;
    end else if (state_q == BF) begin
      mem_q[p] <= bus.bf_apwb;
      mem_q[q] <= bus.bf_anwb;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_data;
  assign bus.bf_a      = bf_a;
  assign bus.bf_b      = bf_b;
  assign bus.bf_w      = bf_w;
endmodule

// File: tb/tb_fft4_sequencer.sv
// tb/tb_fft4_sequencer.sv - randomized self-checking bench for fft4_sequencer with a behavioural butterfly and FFT model
module tb_fft4_sequencer;
  typedef logic [3:0][31:0] frame_t;

  localparam logic [31:0] W0 = 32'h0000_7FFF;
  localparam logic [31:0] W1 = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  fft4_sequencer_if #(.WIDTH(32)) bus();

  fft4_sequencer #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] w, input bit neg);
    logic signed [15:0] br, bi, wr, wi;
    logic signed [31:0] pr, pi;
    logic [15:0] tr, ti, rr, ri;
    br = b[15:0];  bi = b[31:16];
    wr = w[15:0];  wi = w[31:16];
    pr = br * wr - bi * wi;
    pi = br * wi + bi * wr;
    tr = pr[30:15];
    ti = pi[30:15];
    rr = neg ? a[15:0] - tr  : a[15:0] + tr;
    ri = neg ? a[31:16] - ti : a[31:16] + ti;
    return {ri, rr};
  endfunction

  // Decimation-in-time 4-point FFT: even/odd 2-point DFTs, then combine with twiddles 1 and -j.
  function automatic frame_t fft4_model(input frame_t x);
    logic [31:0] e0, e1, o0, o1;
    frame_t r;
    e0 = bfly(x[0], x[2], W0, 1'b0);
    e1 = bfly(x[0], x[2], W0, 1'b1);
    o0 = bfly(x[1], x[3], W0, 1'b0);
    o1 = bfly(x[1], x[3], W0, 1'b1);
    r[0] = bfly(e0, o0, W0, 1'b0);
    r[2] = bfly(e0, o0, W0, 1'b1);
    r[1] = bfly(e1, o1, W1, 1'b0);
    r[3] = bfly(e1, o1, W1, 1'b1);
    return r;
  endfunction

  assign bus.bf_apwb = bfly(bus.bf_a, bus.bf_b, bus.bf_w, 1'b0);
  assign bus.bf_anwb = bfly(bus.bf_a, bus.bf_b, bus.bf_w, 1'b1);

  frame_t imp_f, dc_f, imp_x, dc_x;

  task automatic load_frame(input frame_t f, output int t_last, output bit timeout);
    int n;
    n = 0;
    t_last = 0;
    for (int c = 0; c < 50 && n < 4; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = f[n];
      if (bus.in_ready) begin
        if (n == 3) t_last = cyc;
        n++;
      end
    end
    timeout = (n != 4);
  endtask

  task automatic collect(input bit rnd_ready, input bit in_v, input logic [31:0] in_d,
                         input bit drop_end, output frame_t got, output logic [3:0] lastv,
                         output int t_first, output int in_hs, output bit timeout);
    int k;
    bit first;
    k = 0; first = 1'b1; in_hs = 0; t_first = 0; lastv = '0; got = '0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      @(negedge clk);
      bus.in_valid  = in_v;
      bus.in_data   = in_d;
      bus.out_ready = rnd_ready ? (($urandom & 1) != 0) : 1'b1;
      if (bus.in_valid && bus.in_ready) in_hs++;
      if (bus.out_valid) begin
        if (first) begin t_first = cyc; first = 1'b0; end
        if (bus.out_ready) begin
          got[k]   = bus.out_data;
          lastv[k] = bus.out_last;
          k++;
          if (k == 4 && drop_end) bus.in_valid = 1'b0;
        end
      end
    end
    timeout = (k != 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    tests_run++;
    if ({bus.out_valid, bus.out_last, bus.out_data} !== 34'd0) begin
      tests_failed++; $display("FAIL reset_out got v=%b l=%b d=%h want 0", bus.out_valid, bus.out_last, bus.out_data);
    end
    tests_run++;
    if ({bus.bf_a, bus.bf_b, bus.bf_w} !== 96'd0) begin
      tests_failed++; $display("FAIL reset_bf got %h %h %h want 0", bus.bf_a, bus.bf_b, bus.bf_w);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_impulse();
    frame_t got; logic [3:0] lastv; int t_last, t_first, in_hs; bit to1, to2;
    load_frame(imp_f, t_last, to1);
    collect(1'b0, 1'b0, 32'h0, 1'b1, got, lastv, t_first, in_hs, to2);
    tests_run++;
    if (to1 || to2) begin tests_failed++; $display("FAIL impulse_timeout got %b%b want 00", to1, to2); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got[i] !== imp_x[i]) begin tests_failed++; $display("FAIL impulse_bin%0d got %h want %h", i, got[i], imp_x[i]); end
    end
    tests_run++;
    if (lastv !== 4'b1000) begin tests_failed++; $display("FAIL impulse_last got %b want 1000", lastv); end
    tests_run++;
    if (t_first - t_last !== 5) begin tests_failed++; $display("FAIL impulse_latency got %0d want 5", t_first - t_last); end
  endtask

  task automatic test_dc();
    frame_t got; logic [3:0] lastv; int t_last, t_first, in_hs; bit to1, to2;
    load_frame(dc_f, t_last, to1);
    collect(1'b0, 1'b0, 32'h0, 1'b1, got, lastv, t_first, in_hs, to2);
    tests_run++;
    if (to1 || to2) begin tests_failed++; $display("FAIL dc_timeout got %b%b want 00", to1, to2); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got[i] !== dc_x[i]) begin tests_failed++; $display("FAIL dc_bin%0d got %h want %h", i, got[i], dc_x[i]); end
    end
  endtask

  task automatic test_backpressure();
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int idx, k, t_last, rdy_hi;
    bit to, prev_stall;
    logic [31:0] prev_data;
    idx = 0; k = 0; rdy_hi = 0; prev_stall = 1'b0; prev_data = '0;
    load_frame(dc_f, t_last, to);
    for (int c = 0; c < 100 && k < 4; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = bus.out_valid ? (pat[idx] != 0) : 1'b1;
      if (bus.in_ready) rdy_hi++;
      if (bus.out_valid) begin
        if (prev_stall) begin
          tests_run++;
          if (bus.out_data !== prev_data) begin
            tests_failed++; $display("FAIL bp_hold got %h want %h", bus.out_data, prev_data);
          end
        end
        if (bus.out_ready) begin
          tests_run++;
          if (bus.out_data !== dc_x[k]) begin
            tests_failed++; $display("FAIL bp_bin%0d got %h want %h", k, bus.out_data, dc_x[k]);
          end
          k++;
        end
        prev_stall = !bus.out_ready;
        prev_data  = bus.out_data;
        if (idx < 6) idx++;
      end
    end
    tests_run++;
    if (to || k != 4) begin tests_failed++; $display("FAIL bp_handshakes got %0d want 4", k); end
    tests_run++;
    if (rdy_hi != 0) begin tests_failed++; $display("FAIL bp_in_ready got %0d high cycles want 0", rdy_hi); end
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_after got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_bf();
    frame_t f, got; logic [3:0] lastv; int t_last, t_first, in_hs; bit to1, to2, to3;
    for (int i = 0; i < 4; i++) f[i] = $urandom;
    load_frame(f, t_last, to1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.bf_w !== W0) begin tests_failed++; $display("FAIL midbf_w got %h want %h", bus.bf_w, W0); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL midbf_ctrl got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
    end
    tests_run++;
    if ({bus.bf_a, bus.bf_b, bus.bf_w} !== 96'd0) begin
      tests_failed++; $display("FAIL midbf_bf got %h %h %h want 0", bus.bf_a, bus.bf_b, bus.bf_w);
    end
    load_frame(imp_f, t_last, to2);
    collect(1'b0, 1'b0, 32'h0, 1'b1, got, lastv, t_first, in_hs, to3);
    tests_run++;
    if (to1 || to2 || to3) begin tests_failed++; $display("FAIL midbf_timeout got %b%b%b want 000", to1, to2, to3); end
    tests_run++;
    if (got !== imp_x || lastv !== 4'b1000) begin
      tests_failed++; $display("FAIL midbf_frame got %h last %b want %h last 1000", got, lastv, imp_x);
    end
  endtask

  task automatic test_back_to_back();
    frame_t got1, got2; logic [3:0] l1, l2; int t_last, t_first, hs1, hs2; bit to1, to2, to3, to4;
    load_frame(imp_f, t_last, to1);
    collect(1'b0, 1'b1, dc_f[0], 1'b0, got1, l1, t_first, hs1, to2);
    load_frame(dc_f, t_last, to3);
    collect(1'b0, 1'b0, 32'h0, 1'b1, got2, l2, t_first, hs2, to4);
    tests_run++;
    if (to1 || to2 || to3 || to4) begin tests_failed++; $display("FAIL b2b_timeout got %b%b%b%b want 0000", to1, to2, to3, to4); end
    tests_run++;
    if (hs1 != 0) begin tests_failed++; $display("FAIL b2b_early_accept got %0d want 0", hs1); end
    tests_run++;
    if (got1 !== imp_x || l1 !== 4'b1000) begin tests_failed++; $display("FAIL b2b_frame1 got %h want %h", got1, imp_x); end
    tests_run++;
    if (got2 !== dc_x || l2 !== 4'b1000) begin tests_failed++; $display("FAIL b2b_frame2 got %h want %h", got2, dc_x); end
  endtask

  task automatic test_ignored_input();
    frame_t got; logic [3:0] lastv; int t_last, t_first, in_hs; bit to1, to2;
    load_frame(dc_f, t_last, to1);
    collect(1'b1, 1'b1, 32'h7FFF7FFF, 1'b1, got, lastv, t_first, in_hs, to2);
    tests_run++;
    if (to1 || to2) begin tests_failed++; $display("FAIL ignored_timeout got %b%b want 00", to1, to2); end
    tests_run++;
    if (in_hs != 0) begin tests_failed++; $display("FAIL ignored_consumed got %0d want 0", in_hs); end
    tests_run++;
    if (got !== dc_x) begin tests_failed++; $display("FAIL ignored_frame got %h want %h", got, dc_x); end
  endtask

  task automatic test_random();
    frame_t f, exp_x, got; logic [3:0] lastv; int t_last, t_first, in_hs; bit to1, to2;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) f[i] = $urandom;
      exp_x = fft4_model(f);
      load_frame(f, t_last, to1);
      collect(1'b1, 1'b0, 32'h0, 1'b1, got, lastv, t_first, in_hs, to2);
      tests_run++;
      if (to1 || to2) begin tests_failed++; $display("FAIL rand%0d_timeout got %b%b want 00", n, to1, to2); end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got[i] !== exp_x[i]) begin
          tests_failed++; $display("FAIL rand%0d_bin%0d got %h want %h (in %h)", n, i, got[i], exp_x[i], f);
        end
      end
      tests_run++;
      if (lastv !== 4'b1000) begin tests_failed++; $display("FAIL rand%0d_last got %b want 1000", n, lastv); end
    end
  endtask

  initial begin
    imp_f = {32'h0, 32'h0, 32'h0, 32'h0000_2000};
    imp_x = {4{32'h0000_2000}};
    dc_f  = {4{32'h0000_1000}};
    dc_x  = {32'h0001_0001, 32'h0000_0001, 32'hFFFF_0001, 32'h0000_3FFD};
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_reset_mid_bf();
    test_back_to_back();
    test_ignored_input();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
